// File: rtl/wb_pkg.sv
// Shared widths and arbiter state encoding for the writeback arbiter.
package wb_pkg;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int PEND_W = 32;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } arb_state_e;

  // Which requester filled the output stage; used for same-address ordering.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic: priority register plus combinational grant decode.
//
// state | meaning
// PRI_A | requester A wins when both request
// PRI_B | requester B wins when both request
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic hold_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);
  import wb_pkg::*;

  arb_state_e state_q, state_d;
  logic       allow;

  // Grants are gated by reset so nothing is accepted while the block is held in reset.
  assign allow   = rst_n_i && !hold_i;
  assign gnt_a_o = allow && req_a_i && ((state_q == PRI_A) || !req_b_i);
  assign gnt_b_o = allow && req_b_i && ((state_q == PRI_B) || !req_a_i);

  always_comb begin
    state_d = state_q;
    if (gnt_a_o) begin
      state_d = PRI_B;
    end else if (gnt_b_o) begin
      state_d = PRI_A;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= PRI_A;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two requesters share one registered register-file write port.
// Optional macro WB_PEND_EN adds the Pend mask and same-address reordering protection.
module wb_arbiter #(
  parameter int DW = wb_pkg::DW,
  parameter int AW = wb_pkg::AW
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          ReqA,
  input  logic [AW-1:0] AddrA,
  input  logic [DW-1:0] DataA,
  output logic          AckA,
  input  logic          ReqB,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] DataB,
  output logic          AckB,
  input  logic          Hold,
  output logic [AW-1:0] Wr,
  output logic [DW-1:0] D,
  output logic          We
`ifdef WB_PEND_EN
  ,
  output logic [31:0]   Pend
`endif
);
  import wb_pkg::*;

  logic          req_a_eff, req_b_eff;
  logic          gnt_a, gnt_b;
  logic [AW-1:0] wr_q, wr_d;
  logic [DW-1:0] d_q, d_d;
  logic          we_q, we_d;

`ifdef WB_PEND_EN
  wb_src_e src_q, src_d;

  // Hold off a requester whose address is being written by the other one right now.
  assign req_a_eff = ReqA && !(we_q && (AddrA == wr_q) && (src_q == SRC_B));
  assign req_b_eff = ReqB && !(we_q && (AddrB == wr_q) && (src_q == SRC_A));
  assign Pend      = we_q ? (32'd1 << wr_q) : 32'd0;
`else
  assign req_a_eff = ReqA;
  assign req_b_eff = ReqB;
`endif

  rr_arb2 u_rr_arb2 (
    .clk_i   (Clk),
    .rst_n_i (Clrn),
    .req_a_i (req_a_eff),
    .req_b_i (req_b_eff),
    .hold_i  (Hold),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign AckA = gnt_a;
  assign AckB = gnt_b;

  // r0 is hardwired; a grant to it still completes the handshake but never writes.
  always_comb begin
    wr_d = wr_q;
    d_d  = d_q;
    we_d = 1'b0;
`ifdef WB_PEND_EN
    src_d = SRC_NONE;
`endif
    if (gnt_a) begin
      wr_d = AddrA;
      d_d  = DataA;
      we_d = (AddrA != '0);
`ifdef WB_PEND_EN
      src_d = SRC_A;
`endif
    end else if (gnt_b) begin
      wr_d = AddrB;
      d_d  = DataB;
      we_d = (AddrB != '0);
`ifdef WB_PEND_EN
      src_d = SRC_B;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      wr_q <= '0;
      d_q  <= '0;
      we_q <= 1'b0;
`ifdef WB_PEND_EN
      src_q <= SRC_NONE;
`endif
    end else begin
      wr_q <= wr_d;
      d_q  <= d_d;
      we_q <= we_d;
`ifdef WB_PEND_EN
      src_q <= src_d;
`endif
    end
  end

  assign Wr = wr_q;
  assign D  = d_q;
  assign We = we_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then randomized traffic against a behavioural model.
module tb_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Clrn = 1'b0;
  logic          ReqA = 1'b0, ReqB = 1'b0, Hold = 1'b0;
  logic [AW-1:0] AddrA = '0, AddrB = '0;
  logic [DW-1:0] DataA = '0, DataB = '0;
  logic          AckA, AckB, We;
  logic [AW-1:0] Wr;
  logic [DW-1:0] D;
`ifdef WB_PEND_EN
  logic [31:0]   Pend;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: tie-break owner, contents of the write port, and who filled it.
  bit            m_pri_b;
  bit            m_we;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_d;
  int            m_src;
  bit            e_ack_a, e_ack_b;

  wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .Clk   (Clk),
    .Clrn  (Clrn),
    .ReqA  (ReqA),
    .AddrA (AddrA),
    .DataA (DataA),
    .AckA  (AckA),
    .ReqB  (ReqB),
    .AddrB (AddrB),
    .DataB (DataB),
    .AckB  (AckB),
    .Hold  (Hold),
    .Wr    (Wr),
    .D     (D),
    .We    (We)
`ifdef WB_PEND_EN
    ,
    .Pend  (Pend)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pri_b = 1'b0;
    m_we    = 1'b0;
    m_wr    = '0;
    m_d     = '0;
    m_src   = 0;
  endfunction

  function automatic void predict();
    bit ra, rb;
    ra = ReqA;
    rb = ReqB;
`ifdef WB_PEND_EN
    if (m_we && AddrA == m_wr && m_src == 2) ra = 1'b0;
    if (m_we && AddrB == m_wr && m_src == 1) rb = 1'b0;
`endif
    e_ack_a = 1'b0;
    e_ack_b = 1'b0;
    if (Clrn && !Hold) begin
      if (ra && rb) begin
        if (m_pri_b) e_ack_b = 1'b1;
        else         e_ack_a = 1'b1;
      end else if (ra) begin
        e_ack_a = 1'b1;
      end else if (rb) begin
        e_ack_b = 1'b1;
      end
    end
  endfunction

  function automatic void commit();
    if (e_ack_a) begin
      m_we = (AddrA != 0); m_wr = AddrA; m_d = DataA; m_pri_b = 1'b1; m_src = 1;
    end else if (e_ack_b) begin
      m_we = (AddrB != 0); m_wr = AddrB; m_d = DataB; m_pri_b = 1'b0; m_src = 2;
    end else begin
      m_we = 1'b0; m_src = 0;
    end
  endfunction

  task automatic check_all(input string tag);
    predict();
    chk({tag, "_ackA"}, 64'(AckA), 64'(e_ack_a));
    chk({tag, "_ackB"}, 64'(AckB), 64'(e_ack_b));
    chk({tag, "_we"},   64'(We),   64'(m_we));
    chk({tag, "_wr"},   64'(Wr),   64'(m_wr));
    chk({tag, "_d"},    64'(D),    64'(m_d));
`ifdef WB_PEND_EN
    chk({tag, "_pend"}, 64'(Pend), m_we ? (64'd1 << m_wr) : 64'd0);
`endif
  endtask

  // Called just after a rising edge with inputs already applied; ends just after the next one.
  task automatic step(input string tag);
    #3;
    check_all(tag);
    commit();
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    Clrn = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    ReqA = 1'b0;
    ReqB = 1'b0;
    Hold = 1'b0;
    Clrn = 1'b1;
    #1;
    predict();
    commit();
    @(posedge Clk);
    #1;
  endtask

  bit pa, pb;

  initial begin
    model_reset();
    ReqA = 1'b1; AddrA = 5'd3; ReqB = 1'b1; AddrB = 5'd6;
    #2;
    check_all("reset");
    ReqA = 1'b0; ReqB = 1'b0;
    @(posedge Clk);
    #1;
    Clrn = 1'b1;

    // Single A write to r3
    ReqA = 1'b1; AddrA = 5'd3; DataA = 32'h11111111;
    step("r030_grant");
    ReqA = 1'b0;
    chk("r030_we", 64'(We), 64'd1);
    chk("r030_wr", 64'(Wr), 64'd3);
    chk("r030_d",  64'(D),  64'h11111111);
    step("r030_after");
    chk("r030_we_pulse", 64'(We), 64'd0);

    // B write to r0: acked, no write, state back to PRI_A
    ReqB = 1'b1; AddrB = 5'd0; DataB = 32'hDEADBEEF;
    step("r032_grant");
    ReqB = 1'b0;
    chk("r032_we0", 64'(We), 64'd0);

    // Continuous contention from PRI_A
    ReqA = 1'b1; AddrA = 5'd4; DataA = 32'hA4A4A4A4;
    ReqB = 1'b1; AddrB = 5'd5; DataB = 32'hB5B5B5B5;
    for (int i = 0; i < 4; i++) begin
      step("r031_alt");
      chk("r031_we_seq", 64'(We), 64'd1);
      chk("r031_wr_seq", 64'(Wr), (i % 2 == 0) ? 64'd4 : 64'd5);
    end

    // Hold with both requesting
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) step("r033_hold");
    chk("r033_we_held", 64'(We), 64'd0);
    Hold = 1'b0;
    step("r033_release");
    chk("r033_first_wr", 64'(Wr), 64'd4);
    ReqA = 1'b0; ReqB = 1'b0;
    step("r033_idle");

    // Reset while a write sits in the output stage
    ReqA = 1'b1; AddrA = 5'd9; DataA = 32'h99999999;
    step("r034_grant");
    chk("r034_we_before", 64'(We), 64'd1);
    reset_pulse("r034_reset");
    chk("r034_we_after", 64'(We), 64'd0);
    ReqA = 1'b1; AddrA = 5'd4; DataA = 32'h44;
    ReqB = 1'b1; AddrB = 5'd5; DataB = 32'h55;
    step("r024_first_grant");
    chk("r024_pri_a", 64'(Wr), 64'd4);
    ReqA = 1'b0; ReqB = 1'b0;
    step("r024_idle");

    // A to r7, then B to r7 on the next cycle
    ReqA = 1'b1; AddrA = 5'd7; DataA = 32'h77777777;
    step("r035_a");
    ReqA = 1'b0;
    ReqB = 1'b1; AddrB = 5'd7; DataB = 32'h70707070;
`ifdef WB_PEND_EN
    chk("r035_pend", 64'(Pend), 64'h80);
    #1;
    chk("r035_withheld", 64'(AckB), 64'd0);
`endif
    step("r035_b1");
    if (!e_ack_b) step("r035_b2");
    ReqB = 1'b0;
    step("r035_idle");

    // Randomized traffic with handshake-respecting requesters
    pa = 1'b0; pb = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset_pulse("rnd_reset");
        pa = 1'b0; pb = 1'b0;
      end
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; AddrA = AW'($urandom_range(0, 7)); DataA = $urandom;
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1'b1; AddrB = AW'($urandom_range(0, 7)); DataB = $urandom;
      end
      ReqA = pa;
      ReqB = pb;
      Hold = ($urandom_range(0, 5) == 0);
      step("rnd");
      if (e_ack_a) pa = 1'b0;
      if (e_ack_b) pb = 1'b0;
    end
    ReqA = 1'b0; ReqB = 1'b0; Hold = 1'b0;
    step("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
